rvx_redirect_ctrl: RTL and testbench
====================================

// Module: rvx_redirect_ctrl
// PURPOSE
//  Sequences every PC redirect in the RVX pipeline. Arbitrates between EX-stage jump/branch-taken
//  requests and MEM-stage trap requests, drives pipeline flushes, and hands the winning target
//  to the fetch unit over a valid/ready handshake. Holds the front end in a counted drain window
//  until wrong-path fetches have cleared. Sits between the jump/branch resolution logic and IF.
// PARAMETERS
//  ADDR_W        32  width of redirect target addresses (matches `BUS_W)
//  DRAIN_CYCLES  2   cycles IF/ID stay flushed after the fetch handshake (0..15)
// PORTS
//  clk            input   1       core clock, rising edge
//  rst            input   1       asynchronous, active-low reset
//  jumpReq_EX     input   1       jump (JAL/JALR) or branch taken resolved in EX
//  jumpAddr_EX    input   ADDR_W  jump/branch target
//  trapReq_MEM    input   1       trap raised by the instruction in MEM
//  trapAddr_MEM   input   ADDR_W  trap vector address
//  fetchReady     input   1       IF accepts a redirect this cycle
//  redirValidOut  output  1       redirect target presented to IF
//  redirAddrOut   output  ADDR_W  redirect target, stable while redirValidOut=1
//  flushIFOut     output  1       squash the IF/ID register
//  flushIDOut     output  1       squash the ID/EX register
//  flushEXOut     output  1       squash the EX/MEM register (trap only)
//  stallOut       output  1       freeze PC/IF while a redirect is pending
// BEHAVIOUR
//  - States: IDLE, REQ, DRAIN. Registers: state, addrReg[ADDR_W], isTrapReg, drainCnt[3:0].
//  - Reset (rst=0, async): state=IDLE, addrReg=0, isTrapReg=0, drainCnt=0; all outputs 0.
//  - Priority: trap > jump. Trap is the older instruction; a same-cycle jump is discarded.
//  - Accept: trapReq_MEM is accepted in any state. jumpReq_EX is accepted only in IDLE; in REQ/DRAIN
//    it is wrong-path and ignored. An accepted request latches its target into addrReg and sets isTrapReg.
//  - IDLE: no request -> stay, outputs 0. Request accepted in cycle N -> flushIFOut=flushIDOut=1
//    combinationally in cycle N (flushEXOut=1 too if trap); state=REQ at N+1.
//  - REQ: redirValidOut=1, redirAddrOut=addrReg, stallOut=1, flushIF/ID=1. Handshake = redirValidOut &
//    fetchReady. On handshake: DRAIN_CYCLES=0 -> IDLE; else DRAIN, drainCnt=DRAIN_CYCLES-1.
//    Trap arriving in REQ (including the handshake cycle): replace addrReg, flushEXOut=1 that cycle,
//    stay/return to REQ. The trap overrides the handshake.
//  - DRAIN: flushIF/ID=1, stallOut=0, redirValidOut=0. drainCnt==0 -> IDLE, else decrement.
//    Trap in DRAIN -> latch it, flushEXOut=1, go to REQ.
//  - Latency: request in N -> redirValidOut at N+1; minimum occupancy is 1+DRAIN_CYCLES cycles
//    after the request cycle.
//  - redirValidOut and redirAddrOut are registered (glitch-free). The flushes and stallOut decode
//    state plus the current requests.
//  - redirAddrOut stays stable and redirValidOut never drops while in REQ, except on trap replacement.
//  - Reset mid-operation: immediate return to IDLE; no redirect is re-issued after release.
// TESTING
//  1. IDLE, jumpReq_EX=1 addr 0x100, fetchReady=1 -> N: flushIF/ID=1; N+1: redirValid=1 addr 0x100;
//     N+2,N+3: flushIF/ID=1 valid=0; N+4: all outputs 0.
//  2. Same cycle: trapReq_MEM addr 0x80 and jumpReq_EX addr 0x200 -> flushEXOut=1; N+1: redirAddrOut=0x80.
//  3. Jump 0x104, fetchReady=0 for 3 cycles -> redirValid=1 with addr 0x104 and stallOut=1 held 3 cycles;
//     handshake on the 4th cycle, then DRAIN.
//  4. In REQ with addr 0x104, trapReq_MEM addr 0x80 -> next cycle redirAddrOut=0x80, valid still 1.
//  5. In DRAIN, jumpReq_EX addr 0x300 -> ignored, returns to IDLE on schedule; no redirect to 0x300.
//  6. rst=0 asserted mid-DRAIN -> all outputs 0 immediately; after release, IDLE with no redirect issued.

Source files
------------

// File: rtl/rvx_redirect_ctrl.sv
// rvx_redirect_ctrl: sequences PC redirects (trap over jump), drives pipeline flushes,
// hands the target to IF over valid/ready and holds a counted drain window afterwards.
// Ports: clk, rst (async active-low); jumpReq_EX/jumpAddr_EX from EX; trapReq_MEM/trapAddr_MEM
// from MEM; fetchReady from IF; redirValidOut/redirAddrOut to IF (registered);
// flushIFOut/flushIDOut/flushEXOut/stallOut to the pipeline (decoded from state + requests).
module rvx_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jumpReq_EX,
    input  logic [ADDR_W-1:0] jumpAddr_EX,
    input  logic              trapReq_MEM,
    input  logic [ADDR_W-1:0] trapAddr_MEM,
    input  logic              fetchReady,
    output logic              redirValidOut,
    output logic [ADDR_W-1:0] redirAddrOut,
    output logic              flushIFOut,
    output logic              flushIDOut,
    output logic              flushEXOut,
    output logic              stallOut
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    state_t            state, state_nx;
    logic [3:0]        drain_cnt, drain_cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              accept;
    // A jump seen outside IDLE is on the wrong path; a trap is always older and wins.
    assign accept = trapReq_MEM | (jumpReq_EX & (state == IDLE));
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        addr_nx      = redirAddrOut;
        if (accept) begin
            state_nx = REQ;
            addr_nx  = trapReq_MEM ? trapAddr_MEM : jumpAddr_EX;
        end else if (state == REQ && fetchReady) begin
            state_nx     = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
            drain_cnt_nx = DRAIN_INIT;
        end else if (state == DRAIN) begin
            state_nx     = (drain_cnt == 4'd0) ? IDLE : DRAIN;
            drain_cnt_nx = (drain_cnt == 4'd0) ? 4'd0 : drain_cnt - 4'd1;
        end
        // The target is only presented while a redirect is pending; zero otherwise.
        if (state_nx != REQ) addr_nx = '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            drain_cnt     <= 4'd0;
            redirValidOut <= 1'b0;
            redirAddrOut  <= '0;
        end else begin
            state         <= state_nx;
            drain_cnt     <= drain_cnt_nx;
            redirValidOut <= (state_nx == REQ);
            redirAddrOut  <= addr_nx;
        end
    end
    // Decoded outputs are gated by rst so they read 0 for the whole reset window,
    // even if requests are still toggling upstream.
    assign flushIFOut = rst & ((state != IDLE) | accept);
    assign flushIDOut = rst & ((state != IDLE) | accept);
    assign flushEXOut = rst & trapReq_MEM;
    assign stallOut   = rst & (state == REQ);
endmodule

// File: tb/tb_rvx_redirect_ctrl.sv
module tb_rvx_redirect_ctrl;
    localparam int AW = 32;
    localparam int DC = 2;
    localparam int OW = AW + 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          jumpReq_EX = 1'b0, trapReq_MEM = 1'b0, fetchReady = 1'b0;
    logic [AW-1:0] jumpAddr_EX = '0, trapAddr_MEM = '0;
    logic          redirValidOut, flushIFOut, flushIDOut, flushEXOut, stallOut;
    logic [AW-1:0] redirAddrOut;

    rvx_redirect_ctrl #(.ADDR_W(AW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .jumpReq_EX(jumpReq_EX), .jumpAddr_EX(jumpAddr_EX),
        .trapReq_MEM(trapReq_MEM), .trapAddr_MEM(trapAddr_MEM),
        .fetchReady(fetchReady),
        .redirValidOut(redirValidOut), .redirAddrOut(redirAddrOut),
        .flushIFOut(flushIFOut), .flushIDOut(flushIDOut),
        .flushEXOut(flushEXOut), .stallOut(stallOut)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a pending redirect plus the number of drain cycles still owed.
    logic          m_pend = 1'b0;
    logic [AW-1:0] m_tgt  = '0;
    int            m_drain = 0;

    typedef struct {
        logic          jr;
        logic [AW-1:0] ja;
        logic          tr;
        logic [AW-1:0] ta;
        logic          fr;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [OW-1:0] ex(input logic v, input logic [AW-1:0] a,
                                         input logic f, input logic fe, input logic st);
        return {v, a, f, f, fe, st};
    endfunction

    function automatic logic [OW-1:0] model_out(input logic jr, input logic tr);
        logic idle, fl;
        idle = !m_pend && m_drain == 0;
        fl   = m_pend || m_drain > 0 || tr || (jr && idle);
        return {m_pend, m_pend ? m_tgt : {AW{1'b0}}, fl, fl, tr, m_pend};
    endfunction

    task automatic model_step(input logic jr, input logic [AW-1:0] ja, input logic tr,
                              input logic [AW-1:0] ta, input logic fr);
        logic idle;
        idle = !m_pend && m_drain == 0;
        if (tr) begin
            m_pend = 1'b1; m_tgt = ta; m_drain = 0;
        end else if (jr && idle) begin
            m_pend = 1'b1; m_tgt = ja;
        end else if (m_pend && fr) begin
            m_pend = 1'b0; m_drain = DC;
        end else if (m_drain > 0) begin
            m_drain--;
        end
    endtask

    function automatic logic [OW-1:0] dut_out();
        return {redirValidOut, redirAddrOut, flushIFOut, flushIDOut, flushEXOut, stallOut};
    endfunction

    task automatic check(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%b a=%h fif=%b fid=%b fex=%b st=%b, want v=%b a=%h fif=%b fid=%b fex=%b st=%b",
                     nm, got[OW-1], got[OW-2:4], got[3], got[2], got[1], got[0],
                     exp[OW-1], exp[OW-2:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Apply inputs at negedge, compare just after, then advance model at the posedge.
    task automatic cyc(input logic jr, input logic [AW-1:0] ja, input logic tr,
                       input logic [AW-1:0] ta, input logic fr,
                       input logic use_exp, input logic [OW-1:0] exp, input string nm);
        @(negedge clk);
        jumpReq_EX = jr; jumpAddr_EX = ja; trapReq_MEM = tr; trapAddr_MEM = ta; fetchReady = fr;
        #1;
        check(nm, dut_out(), use_exp ? exp : model_out(jr, tr));
        @(posedge clk);
        model_step(jr, ja, tr, ta, fr);
    endtask

    task automatic add(input logic jr, input logic [AW-1:0] ja, input logic tr,
                       input logic [AW-1:0] ta, input logic fr,
                       input logic v, input logic [AW-1:0] a, input logic f,
                       input logic fe, input logic st);
        vec_t t;
        t.jr = jr; t.ja = ja; t.tr = tr; t.ta = ta; t.fr = fr; t.exp = ex(v, a, f, fe, st);
        vq.push_back(t);
    endtask

    initial begin
        // jump, immediate handshake, two drain cycles, idle
        add(1, 'h100, 0, 0, 1,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0, 1,  1, 'h100, 1, 0, 1);
        add(0, 0,     0, 0, 1,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0, 1,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0, 1,  0, 'h000, 0, 0, 0);
        // same-cycle trap and jump: trap wins
        add(1, 'h200, 1, 'h80, 0,  0, 'h000, 1, 1, 0);
        add(0, 0,     0, 0,    0,  1, 'h080, 1, 0, 1);
        add(0, 0,     0, 0,    1,  1, 'h080, 1, 0, 1);
        add(0, 0,     0, 0,    0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0,    0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0,    0,  0, 'h000, 0, 0, 0);
        // fetch back-pressure for three cycles, then handshake; wrong-path jumps in drain ignored
        add(1, 'h104, 0, 0, 0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0, 0,  1, 'h104, 1, 0, 1);
        add(0, 0,     0, 0, 0,  1, 'h104, 1, 0, 1);
        add(0, 0,     0, 0, 0,  1, 'h104, 1, 0, 1);
        add(0, 0,     0, 0, 1,  1, 'h104, 1, 0, 1);
        add(1, 'h300, 0, 0, 0,  0, 'h000, 1, 0, 0);
        add(1, 'h300, 0, 0, 0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0, 0,  0, 'h000, 0, 0, 0);
        // trap replaces pending jump; trap on the handshake cycle; trap during drain
        add(1, 'h104, 0, 0,     0,  0, 'h000, 1, 0, 0);
        add(0, 0,     1, 'h80,  0,  1, 'h104, 1, 1, 1);
        add(1, 'h500, 0, 0,     0,  1, 'h080, 1, 0, 1);
        add(0, 0,     1, 'h90,  1,  1, 'h080, 1, 1, 1);
        add(0, 0,     0, 0,     1,  1, 'h090, 1, 0, 1);
        add(0, 0,     1, 'hA0,  0,  0, 'h000, 1, 1, 0);
        add(0, 0,     0, 0,     1,  1, 'h0A0, 1, 0, 1);
        add(0, 0,     0, 0,     0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0,     0,  0, 'h000, 1, 0, 0);
        add(0, 0,     0, 0,     0,  0, 'h000, 0, 0, 0);

        // outputs stay 0 during reset even with requests asserted
        repeat (2) @(negedge clk);
        jumpReq_EX = 1; jumpAddr_EX = 'h44; trapReq_MEM = 1; trapAddr_MEM = 'h88;
        #1;
        check("reset_hold", dut_out(), '0);
        @(negedge clk);
        jumpReq_EX = 0; trapReq_MEM = 0; jumpAddr_EX = '0; trapAddr_MEM = '0;
        rst = 1;
        #1;
        check("reset_release", dut_out(), '0);

        foreach (vq[i])
            cyc(vq[i].jr, vq[i].ja, vq[i].tr, vq[i].ta, vq[i].fr, 1'b1, vq[i].exp,
                $sformatf("vec%0d", i));

        // async reset asserted mid-drain
        cyc(1, 'h100, 0, 0, 1, 1'b1, ex(0, 0, 1, 0, 0), "rst_seq_req");
        cyc(0, 0, 0, 0, 1, 1'b1, ex(1, 'h100, 1, 0, 1), "rst_seq_hs");
        @(negedge clk);
        jumpReq_EX = 1; jumpAddr_EX = 'h300;
        #1;
        check("rst_seq_drain", dut_out(), ex(0, 0, 1, 0, 0));
        #1 rst = 0;
        #1;
        check("rst_mid_drain", dut_out(), '0);
        @(negedge clk);
        jumpReq_EX = 0; jumpAddr_EX = '0;
        rst = 1;
        m_pend = 0; m_drain = 0; m_tgt = '0;
        #1;
        check("rst_after", dut_out(), '0);
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 1, 1'b1, '0, $sformatf("rst_idle%0d", i));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom,
                $urandom_range(0, 1) == 1, 1'b0, '0, $sformatf("rand%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
